// File: rtl/step_driver_pkg.sv
// Shared definitions for the step driver: FSM state encoding and default
// configuration constants.
package step_driver_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_GAP   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/step_driver_if.sv
// Command/status bundle between a move requester (master) and the step
// driver (slave).
//   i_start, i_target, i_abort         : move request, destination, cancel
//   i_sync_load, i_sync_value          : shadow position resynchronisation
//   o_increase, o_decrease             : step pulses to the driven counter
//   o_busy, o_done, o_position         : move status and shadow position
interface step_driver_if
    import step_driver_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    localparam int unsigned PW = WIDTH + 1;

    logic          i_start;
    logic [PW-1:0] i_target;
    logic          i_abort;
    logic          i_sync_load;
    logic [PW-1:0] i_sync_value;
    logic          o_increase;
    logic          o_decrease;
    logic          o_busy;
    logic          o_done;
    logic [PW-1:0] o_position;

    modport master (
        output i_start, i_target, i_abort, i_sync_load, i_sync_value,
        input  o_increase, o_decrease, o_busy, o_done, o_position
    );

    modport slave (
        input  i_start, i_target, i_abort, i_sync_load, i_sync_value,
        output o_increase, o_decrease, o_busy, o_done, o_position
    );

endinterface

// File: rtl/step_gap_timer.sv
// Inter-step gap timer: i_load arms it for GAP cycles, o_expired_c goes high
// on the last of them. Only built when STEP_GAP_EN is defined.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : start a new gap
//   o_expired_c  : combinational, gap has run out
`ifdef STEP_GAP_EN
module step_gap_timer
    import step_driver_pkg::*;
#(
    parameter int unsigned GAP = DEF_GAP
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_expired_c
);

    localparam int unsigned TW   = (GAP > 1) ? $clog2(GAP) : 1;
    // The load cycle itself is the first gap cycle, so count GAP-1 more.
    localparam int unsigned LOAD = (GAP > 0) ? GAP - 1 : 0;

    logic [TW-1:0] r_count;

    // Load-and-count-down register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= TW'(LOAD);
        end else if (r_count != '0) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign o_expired_c = (r_count == '0);

endmodule
`endif

// File: rtl/step_driver.sv
// Step driver: walks the shadow position toward a latched target by issuing
// single-cycle increase/decrease pulses to an external up/down counter.
// Optional feature macro: STEP_GAP_EN inserts GAP idle cycles after each pulse.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : step_driver_if.slave (start/target/abort/sync in, pulses/status out)
module step_driver
    import step_driver_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned GAP   = DEF_GAP
) (
    input  logic         clk,
    input  logic         rst,
    step_driver_if.slave bus
);

    localparam int unsigned PW = WIDTH + 1;

    if (WIDTH < 1 || WIDTH > 30 || GAP > 1024) begin : g_bad_cfg
        $error("step_driver: unsupported WIDTH/GAP configuration");
    end

    state_t        r_state;
    state_t        w_state_n;
    logic          r_increase;
    logic          r_decrease;
    logic          r_busy;
    logic          r_done;
    logic [PW-1:0] r_position;
    logic [PW-1:0] r_target;
    logic          w_increase_n;
    logic          w_decrease_n;
    logic          w_busy_n;
    logic          w_done_n;
    logic [PW-1:0] w_position_n;
    logic [PW-1:0] w_target_n;

`ifdef STEP_GAP_EN
    logic w_gap_load;
    logic w_gap_expired;

    step_gap_timer #(
        .GAP (GAP)
    ) u_gap_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_gap_load),
        .o_expired_c (w_gap_expired)
    );
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_increase <= 1'b0;
            r_decrease <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_position <= '0;
            r_target   <= '0;
        end else begin
            r_state    <= w_state_n;
            r_increase <= w_increase_n;
            r_decrease <= w_decrease_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_position <= w_position_n;
            r_target   <= w_target_n;
        end
    end

    // Next state and next output values
    always_comb begin
        w_state_n    = r_state;
        w_increase_n = 1'b0;
        w_decrease_n = 1'b0;
        w_busy_n     = r_busy;
        w_done_n     = 1'b0;
        w_position_n = r_position;
        w_target_n   = r_target;
`ifdef STEP_GAP_EN
        w_gap_load   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_busy_n = 1'b0;
                // Resync lands first so a same-cycle start moves from sync_value.
                if (bus.i_sync_load) begin
                    w_position_n = bus.i_sync_value;
                end
                if (bus.i_start && !bus.i_abort) begin
                    w_target_n = bus.i_target;
                    w_state_n  = S_STEP;
                    w_busy_n   = 1'b1;
                end
            end
            S_STEP: begin
                if (bus.i_abort) begin
                    w_state_n = S_IDLE;
                    w_busy_n  = 1'b0;
                end else if (r_position != r_target) begin
                    // Pulse and shadow update are registered together.
                    if (r_position < r_target) begin
                        w_increase_n = 1'b1;
                        w_position_n = r_position + PW'(1);
                    end else begin
                        w_decrease_n = 1'b1;
                        w_position_n = r_position - PW'(1);
                    end
`ifdef STEP_GAP_EN
                    if (GAP != 0) begin
                        w_state_n  = S_GAP;
                        w_gap_load = 1'b1;
                    end
`endif
                end else begin
                    w_state_n = S_DONE;
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                end
            end
`ifdef STEP_GAP_EN
            S_GAP: begin
                if (bus.i_abort) begin
                    w_state_n = S_IDLE;
                    w_busy_n  = 1'b0;
                end else if (w_gap_expired) begin
                    w_state_n = S_STEP;
                end
            end
`endif
            S_DONE: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
            end
            default: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.o_increase = r_increase;
    assign bus.o_decrease = r_decrease;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_position = r_position;

endmodule
